// File: rtl/matrix_result_drain_pkg.sv
// Shared types and width helpers for the matrix result drain.
package matrix_result_drain_pkg;

    // Drain controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } drain_state_e;

    // Width of the flat element index: must hold N*N (one past the last index).
    function automatic int idx_w(input int n);
        return $clog2(n * n) + 1;
    endfunction

    // Width of the row/column indices; at least one bit even when N=1.
    function automatic int rc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_result_drain_if.sv
// Valid/ready element stream carrying one C-matrix element per transfer.
interface matrix_result_drain_if #(
    parameter int WIDTH = 16,
    parameter int IW    = 2
);
    logic [2*WIDTH-1:0] data;
    logic               valid;
    logic               ready;
    logic [IW-1:0]      row;
    logic [IW-1:0]      col;
    logic               last;

    modport master (output data, valid, row, col, last, input ready);
    modport slave  (input data, valid, row, col, last, output ready);
endinterface

// File: rtl/matrix_result_drain.sv
// Waits out the multiplier latency after a start, snapshots the C matrix,
// then streams it row-major over a registered valid/ready interface.
module matrix_result_drain
    import matrix_result_drain_pkg::*;
#(
    parameter int N           = 4,
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 10,
    parameter int LATENCY     = PIPE_STAGES + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_i,
    input  logic [N-1:0][N-1:0][2*WIDTH-1:0]    c_in_i,
    matrix_result_drain_if.master               out_if,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                start_dropped_o
);

    localparam int IDXW = idx_w(N);
    localparam int IW   = rc_w(N);
    localparam int TW   = $clog2(LATENCY + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N * N - 1);

    typedef logic [2*WIDTH-1:0] elem_t;

    drain_state_e                    state_q;
    logic [TW-1:0]                   timer_q;
    logic [IDXW-1:0]                 idx_q, idx_d;
    logic [IW-1:0]                   row_q, row_d;
    logic [IW-1:0]                   col_q, col_d;
    logic                            valid_q;
    elem_t                           data_q;
    logic                            last_q;
    logic                            done_q;
    logic                            drop_q;
    logic [N-1:0][N-1:0][2*WIDTH-1:0] buf_q;

    logic capture;
    logic xfer;

    // Capture edge, transfer qualifier and next row-major position.
    always_comb begin
        capture = (state_q == WAIT) && (timer_q == TW'(1));
        xfer    = (state_q == STREAM) && valid_q && out_if.ready;
        idx_d   = idx_q + IDXW'(1);
        row_d   = row_q;
        col_d   = col_q + IW'(1);
        if (col_q == IW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + IW'(1);
        end
    end

    // Snapshot of C; isolates the stream from the multiplier's next job.
    always_ff @(posedge clk) begin
        if (capture) buf_q <= c_in_i;
    end

    // Controller FSM with all stream outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A start is only honoured from IDLE, including at the final transfer.
            drop_q <= start_i && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= WAIT;
                        timer_q <= TW'(LATENCY);
                    end
                end
                WAIT: begin
                    timer_q <= timer_q - TW'(1);
                    if (capture) begin
                        state_q <= STREAM;
                        idx_q   <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        valid_q <= 1'b1;
                        data_q  <= c_in_i[0][0];
                        last_q  <= (N == 1);
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_d;
                            row_q  <= row_d;
                            col_q  <= col_d;
                            data_q <= buf_q[row_d][col_d];
                            last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.valid    = valid_q;
    assign out_if.data     = data_q;
    assign out_if.row      = row_q;
    assign out_if.col      = col_q;
    assign out_if.last     = last_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign start_dropped_o = drop_q;

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed and randomized checks of the matrix result drain against a
// matrix-multiply reference model.
module tb_matrix_result_drain;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int LAT = 11;

    typedef logic [N-1:0][N-1:0][W-1:0]   opm_t;
    typedef logic [N-1:0][N-1:0][2*W-1:0] cm_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    cm_t  c_in;
    logic busy, done, dropped;

    int nchk  = 0;
    int npass = 0;

    matrix_result_drain_if #(.WIDTH(W), .IW(2)) oif ();

    matrix_result_drain #(.N(N), .WIDTH(W), .PIPE_STAGES(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .c_in_i          (c_in),
        .out_if          (oif),
        .busy_o          (busy),
        .done_o          (done),
        .start_dropped_o (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: C = A*B with products and sums wrapping at 2*W bits.
    function automatic cm_t matmul(input opm_t a, input opm_t b);
        cm_t c;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [2*W-1:0] acc = '0;
                for (int k = 0; k < N; k++)
                    acc += (2*W)'(a[i][k]) * (2*W)'(b[k][j]);
                c[i][j] = acc;
            end
        return c;
    endfunction

    function automatic cm_t garbage();
        cm_t g;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) g[i][j] = $urandom();
        return g;
    endfunction

    function automatic opm_t rand_m();
        opm_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = W'($urandom());
        return m;
    endfunction

    // One operation, entered and left at a negedge. c_in only holds the true
    // product for the single cycle before the capture edge.
    // mode: 0 always ready, 1 stall at stall_idx for stall_len, 2 random ready.
    task automatic run_op(input opm_t a, input opm_t b, input int mode,
                          input int stall_idx, input int stall_len,
                          input int wait_drop, input int stream_drop, input int abort_at);
        cm_t c;
        logic [2*W-1:0] exp_q[$];
        int k = 0, stalled = 0, cyc = 0;
        bit pend = 0, drop_used = 0, aborted = 0;
        c = matmul(a, b);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_q.push_back(c[i][j]);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c_in  = garbage();
        check("busy_after_start", busy, 1);
        for (int e = 1; e < LAT; e++) begin
            start = (e == wait_drop);
            @(posedge clk); #1;
            start = 1'b0;
            if (e == wait_drop) check("drop_in_wait", dropped, 1);
            check("valid_low_in_wait", oif.valid, 0);
            c_in = (e == LAT - 1) ? c : garbage();
        end
        @(posedge clk); #1;
        c_in = garbage();
        check("valid_at_latency", oif.valid, 1);

        while (k < N * N && cyc < 400) begin
            if (pend) begin
                check("drop_in_stream", dropped, 1);
                pend = 0;
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                oif.ready = 1'b0;
                #1;
                check("abort_valid", oif.valid, 0);
                check("abort_busy", busy, 0);
                check("abort_data", oif.data, 0);
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                end
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            case (mode)
                0: oif.ready = 1'b1;
                1: begin
                    oif.ready = !(k == stall_idx && stalled < stall_len);
                    if (!oif.ready) stalled++;
                end
                default: oif.ready = ($urandom_range(0, 2) != 0);
            endcase
            if (k == stream_drop && !drop_used) begin
                start = 1'b1;
                pend = 1;
                drop_used = 1;
            end
            @(negedge clk);
            check("stream_valid", oif.valid, 1);
            check("stream_data", oif.data, exp_q[k]);
            check("stream_row", oif.row, 64'(k / N));
            check("stream_col", oif.col, 64'(k % N));
            check("stream_last", oif.last, (k == N * N - 1));
            if (oif.ready) k++;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        if (aborted) return;
        if (cyc >= 400) check("stream_timeout", k, N * N);
        if (pend) check("drop_at_final", dropped, 1);
        check("done_pulse", done, 1);
        check("valid_after_last", oif.valid, 0);
        check("busy_after_last", busy, 0);
        oif.ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        opm_t a_ipj, ident, ones, a2;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_ipj[i][j] = W'(i + j);
                ident[i][j] = (i == j) ? W'(1) : W'(0);
                a2[i][j]    = (i == j) ? W'(2) : W'(0);
                ones[i][j]  = 16'hFFFF;
            end
        rst_n = 1'b0;
        start = 1'b0;
        oif.ready = 1'b0;
        c_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", oif.valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dropped", dropped, 0);
        check("rst_data", oif.data, 0);
        check("rst_last", oif.last, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(a_ipj, ident, 0, 0, 0, -1, -1, -1);     // basic stream
        run_op(a_ipj, ident, 1, 5, 5, -1, -1, -1);     // backpressure at idx 5
        run_op(a_ipj, ident, 0, 0, 0, 3, 9, -1);       // dropped starts
        run_op(ones, ones, 0, 0, 0, -1, -1, -1);       // wrap values
        run_op(a_ipj, ident, 0, 0, 0, -1, -1, 7);      // reset mid-stream
        @(negedge clk);
        check("idle_after_abort", busy, 0);
        run_op(a_ipj, ident, 0, 0, 0, -1, -1, -1);     // full stream after reset
        run_op(a2, ident, 0, 0, 0, -1, -1, -1);        // back-to-back after done
        for (int t = 0; t < 4; t++)
            run_op(rand_m(), rand_m(), 2, 0, 0, -1,
                   (t == 3) ? N * N - 1 : int'($urandom_range(0, N * N - 1)), -1);
        @(negedge clk);
        check("final_idle_done", done, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
